// File: rtl/pipe_mul_if.sv
// Operand, control and result bundle for pipe_mul.
// The master drives samples and controls; the slave (the multiplier) returns results.
interface pipe_mul_if #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int OUT_W   = 16,
    parameter int TAG_W   = 4
);
    logic               ce;
    logic               in_valid;
    logic               signed_mode;
    logic [WIDTH_A-1:0] a;
    logic [WIDTH_B-1:0] b;
    logic [TAG_W-1:0]   tag;
    logic               ovf_clr;
    logic [OUT_W-1:0]   res;
    logic               res_dv;
    logic [TAG_W-1:0]   res_tag;
    logic               res_sat;
    logic               ovf_sticky;

    modport master (
        output ce, in_valid, signed_mode, a, b, tag, ovf_clr,
        input  res, res_dv, res_tag, res_sat, ovf_sticky
    );

    modport slave (
        input  ce, in_valid, signed_mode, a, b, tag, ovf_clr,
        output res, res_dv, res_tag, res_sat, ovf_sticky
    );
endinterface

// File: rtl/pipe_mul.sv
// Pipelined signed/unsigned multiplier with round-half-up post-scale, output saturation
// and a per-sample tag; STAGES ce-enabled cycles of latency.
module pipe_mul #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 0,
    parameter int STAGES  = 2,
    parameter int TAG_W   = 4
) (
    input  logic      clk,
    input  logic      rst,
    pipe_mul_if.slave bus
);

    localparam int PW  = WIDTH_A + WIDTH_B;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    // One extra bit keeps the rounding add from wrapping and lets unsigned values stay positive.
    localparam logic signed [PW:0] RND  = (SHIFT > 0) ? ((PW+1)'(1) << RSH) : '0;
    localparam logic signed [PW:0] UMAX = ((PW+1)'(1) << OUT_W) - (PW+1)'(1);
    localparam logic signed [PW:0] SMAX = UMAX >>> 1;
    localparam logic signed [PW:0] SMIN = ~SMAX;

    logic signed [PW:0] aExt;
    logic signed [PW:0] bExt;
    logic signed [PW:0] prodIn;

    always_comb begin
        aExt   = bus.signed_mode ? (PW+1)'($signed(bus.a)) : (PW+1)'(bus.a);
        bExt   = bus.signed_mode ? (PW+1)'($signed(bus.b)) : (PW+1)'(bus.b);
        prodIn = aExt * bExt;
    end

    logic signed [PW:0] lastProd;
    logic               lastMode;
    logic               lastValid;
    logic [TAG_W-1:0]   lastTag;

    // Stages ahead of the output register carry the full product; the last stage scales and clips.
    generate
        if (STAGES > 1) begin : g_pipe
            logic signed [PW:0] prodPipe_q  [STAGES-1];
            logic               modePipe_q  [STAGES-1];
            logic               validPipe_q [STAGES-1];
            logic [TAG_W-1:0]   tagPipe_q   [STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES - 1; i++) begin
                        prodPipe_q[i]  <= '0;
                        modePipe_q[i]  <= 1'b0;
                        validPipe_q[i] <= 1'b0;
                        tagPipe_q[i]   <= '0;
                    end
                end else if (bus.ce) begin
                    prodPipe_q[0]  <= prodIn;
                    modePipe_q[0]  <= bus.signed_mode;
                    validPipe_q[0] <= bus.in_valid;
                    tagPipe_q[0]   <= bus.tag;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        prodPipe_q[i]  <= prodPipe_q[i-1];
                        modePipe_q[i]  <= modePipe_q[i-1];
                        validPipe_q[i] <= validPipe_q[i-1];
                        tagPipe_q[i]   <= tagPipe_q[i-1];
                    end
                end
            end

            assign lastProd  = prodPipe_q[STAGES-2];
            assign lastMode  = modePipe_q[STAGES-2];
            assign lastValid = validPipe_q[STAGES-2];
            assign lastTag   = tagPipe_q[STAGES-2];
        end else begin : g_direct
            assign lastProd  = prodIn;
            assign lastMode  = bus.signed_mode;
            assign lastValid = bus.in_valid;
            assign lastTag   = bus.tag;
        end
    endgenerate

    logic signed [PW:0] scaled;
    logic [OUT_W-1:0]   res_d;
    logic               sat_d;
    logic               ovf_d;

    logic [OUT_W-1:0]   res_q;
    logic               sat_q;
    logic               dv_q;
    logic [TAG_W-1:0]   tag_q;
    logic               ovf_q;

    // Unsigned products keep a zero top bit, so the arithmetic shift also serves as a logical one.
    always_comb begin
        scaled = (lastProd + RND) >>> SHIFT;
        res_d  = scaled[OUT_W-1:0];
        sat_d  = 1'b0;
        if (lastMode) begin
            if (scaled > SMAX) begin
                res_d = SMAX[OUT_W-1:0];
                sat_d = 1'b1;
            end else if (scaled < SMIN) begin
                res_d = SMIN[OUT_W-1:0];
                sat_d = 1'b1;
            end
        end else if (scaled > UMAX) begin
            res_d = UMAX[OUT_W-1:0];
            sat_d = 1'b1;
        end
        ovf_d = (dv_q && sat_q) || (ovf_q && !bus.ovf_clr);
    end

    // Results load only on a valid advance, so bubbles and stalls leave the last result in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            sat_q <= 1'b0;
            dv_q  <= 1'b0;
            tag_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (bus.ce) begin
                dv_q <= lastValid;
                if (lastValid) begin
                    res_q <= res_d;
                    sat_q <= sat_d;
                    tag_q <= lastTag;
                end
            end else begin
                dv_q <= 1'b0;
            end
        end
    end

    assign bus.res        = res_q;
    assign bus.res_dv     = dv_q;
    assign bus.res_tag    = tag_q;
    assign bus.res_sat    = sat_q;
    assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_pipe_mul.sv
// Drives three pipe_mul configurations with shared stimulus and compares every cycle
// against an arithmetic reference model with a per-sample latency queue.
module tb_pipe_mul;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       inValid;
    logic       signedMode;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
    logic       ovfClr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_mul_if #(.WIDTH_A(8), .WIDTH_B(8), .OUT_W(16), .TAG_W(4)) bus0 ();
    pipe_mul_if #(.WIDTH_A(8), .WIDTH_B(8), .OUT_W(8),  .TAG_W(4)) bus1 ();
    pipe_mul_if #(.WIDTH_A(8), .WIDTH_B(8), .OUT_W(12), .TAG_W(4)) bus2 ();

    assign bus0.ce = ce;  assign bus0.in_valid = inValid;  assign bus0.signed_mode = signedMode;
    assign bus0.a  = a;   assign bus0.b = b;  assign bus0.tag = tag;  assign bus0.ovf_clr = ovfClr;
    assign bus1.ce = ce;  assign bus1.in_valid = inValid;  assign bus1.signed_mode = signedMode;
    assign bus1.a  = a;   assign bus1.b = b;  assign bus1.tag = tag;  assign bus1.ovf_clr = ovfClr;
    assign bus2.ce = ce;  assign bus2.in_valid = inValid;  assign bus2.signed_mode = signedMode;
    assign bus2.a  = a;   assign bus2.b = b;  assign bus2.tag = tag;  assign bus2.ovf_clr = ovfClr;

    pipe_mul #(.WIDTH_A(8), .WIDTH_B(8), .OUT_W(16), .SHIFT(0), .STAGES(2), .TAG_W(4))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipe_mul #(.WIDTH_A(8), .WIDTH_B(8), .OUT_W(8),  .SHIFT(0), .STAGES(2), .TAG_W(4))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipe_mul #(.WIDTH_A(8), .WIDTH_B(8), .OUT_W(12), .SHIFT(4), .STAGES(3), .TAG_W(4))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int cfgStages [3] = '{2, 2, 3};
    int cfgOutW   [3] = '{16, 8, 12};
    int cfgShift  [3] = '{0, 0, 4};

    typedef struct {
        int          inst;
        int          left;
        logic [15:0] res;
        logic        sat;
        logic [3:0]  tag;
    } item_t;

    item_t pend [$];

    logic [15:0] expRes [3];
    logic [3:0]  expTag [3];
    logic        expSat [3];
    logic        expDv  [3];
    logic        expOvf [3];

    // Exact product, floor((P + half) / 2^shift), then clamp to the output range.
    function automatic logic [16:0] refCalc(input logic [7:0] av, input logic [7:0] bv,
                                            input logic sm, input int ow, input int sh);
        longint p;
        longint r;
        longint lo;
        longint hi;
        logic   sat;
        if (sm) p = longint'($signed(av)) * longint'($signed(bv));
        else    p = longint'(av) * longint'(bv);
        r = p;
        if (sh > 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
        if (sm) begin
            hi = (longint'(1) << (ow - 1)) - 1;
            lo = -(longint'(1) << (ow - 1));
        end else begin
            hi = (longint'(1) << ow) - 1;
            lo = 0;
        end
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        r = r & ((longint'(1) << ow) - 1);
        return {sat, r[15:0]};
    endfunction

    task automatic checkValue(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] gotRes [3];
        logic [3:0]  gotTag [3];
        logic        gotSat [3];
        logic        gotDv  [3];
        logic        gotOvf [3];
        gotRes[0] = bus0.res;         gotRes[1] = 16'(bus1.res);   gotRes[2] = 16'(bus2.res);
        gotTag[0] = bus0.res_tag;     gotTag[1] = bus1.res_tag;    gotTag[2] = bus2.res_tag;
        gotSat[0] = bus0.res_sat;     gotSat[1] = bus1.res_sat;    gotSat[2] = bus2.res_sat;
        gotDv[0]  = bus0.res_dv;      gotDv[1]  = bus1.res_dv;     gotDv[2]  = bus2.res_dv;
        gotOvf[0] = bus0.ovf_sticky;  gotOvf[1] = bus1.ovf_sticky; gotOvf[2] = bus2.ovf_sticky;
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (gotDv[i] === expDv[i]) else begin
                errors++;
                $error("[TB] FAIL dv dut%0d t=%0t got %b want %b", i, $time, gotDv[i], expDv[i]);
            end
            checks++;
            assert ({gotRes[i], gotTag[i], gotSat[i], gotOvf[i]} ===
                    {expRes[i], expTag[i], expSat[i], expOvf[i]}) else begin
                errors++;
                $error("[TB] FAIL out dut%0d t=%0t got res=%0h tag=%0h sat=%b ovf=%b want res=%0h tag=%0h sat=%b ovf=%b",
                       i, $time, gotRes[i], gotTag[i], gotSat[i], gotOvf[i],
                       expRes[i], expTag[i], expSat[i], expOvf[i]);
            end
        end
    endtask

    // One clock: drive inputs, advance the reference model at the edge, then compare.
    task automatic applyStimulus(input logic r, input logic c, input logic v, input logic sm,
                                 input logic [7:0] av, input logic [7:0] bv,
                                 input logic [3:0] tv, input logic clr);
        item_t keep [$];
        item_t it;
        logic [16:0] calc;
        rst = r; ce = c; inValid = v; signedMode = sm; a = av; b = bv; tag = tv; ovfClr = clr;
        @(posedge clk);
        if (r) begin
            pend.delete();
            for (int i = 0; i < 3; i++) begin
                expRes[i] = '0; expTag[i] = '0; expSat[i] = 1'b0; expDv[i] = 1'b0; expOvf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                expOvf[i] = (expDv[i] && expSat[i]) || (expOvf[i] && !clr);
                expDv[i]  = 1'b0;
            end
            if (c) begin
                if (v) begin
                    for (int i = 0; i < 3; i++) begin
                        calc    = refCalc(av, bv, sm, cfgOutW[i], cfgShift[i]);
                        it.inst = i;
                        it.left = cfgStages[i];
                        it.res  = calc[15:0];
                        it.sat  = calc[16];
                        it.tag  = tv;
                        pend.push_back(it);
                    end
                end
                foreach (pend[k]) begin
                    it = pend[k];
                    it.left--;
                    if (it.left == 0) begin
                        expRes[it.inst] = it.res;
                        expSat[it.inst] = it.sat;
                        expTag[it.inst] = it.tag;
                        expDv[it.inst]  = 1'b1;
                    end else begin
                        keep.push_back(it);
                    end
                end
                pend = keep;
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        logic stallCe [7];
        $display("[TB] pipe_mul bench starting");

        applyStimulus(1, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        applyStimulus(1, 1, 1, 0, 8'd5, 8'd5, 4'd9, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);

        // Unsigned full-scale product, two-cycle latency on dut0.
        applyStimulus(0, 1, 1, 0, 8'd255, 8'd255, 4'd1, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        checkValue("u255x255_res", bus0.res, 16'd65025);
        checkValue("u255x255_dv", 16'(bus0.res_dv), 16'd1);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        checkValue("u255x255_once", 16'(bus0.res_dv), 16'd0);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);

        // Back-to-back mixed-mode samples.
        applyStimulus(0, 1, 1, 1, 8'h80, 8'h80, 4'd1, 0);
        applyStimulus(0, 1, 1, 1, 8'h80, 8'h7F, 4'd2, 0);
        applyStimulus(0, 1, 1, 0, 8'd128, 8'd128, 4'd3, 0);
        checkValue("s-128x127", bus0.res, 16'hC080);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        checkValue("u128x128_tag", 16'(bus0.res_tag), 16'd3);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 1);
        checkValue("ovf_cleared", 16'(bus1.ovf_sticky), 16'd0);

        // Saturation on the 8-bit output; clear coincides with a saturating result.
        applyStimulus(0, 1, 1, 0, 8'd20, 8'd20, 4'd4, 0);
        applyStimulus(0, 1, 1, 1, 8'd100, 8'd100, 4'd5, 0);
        checkValue("u20x20_sat", bus1.res_sat ? 16'(bus1.res) : 16'hFFFF, 16'd255);
        applyStimulus(0, 1, 1, 1, 8'h9C, 8'd100, 4'd6, 1);
        checkValue("ovf_set_wins", 16'(bus1.ovf_sticky), 16'd1);
        checkValue("s100x100", 16'(bus1.res), 16'h7F);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        checkValue("s-100x100", 16'(bus1.res), 16'h80);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);

        // Round-half-up on dut2 (SHIFT=4, three stages).
        applyStimulus(0, 1, 1, 0, 8'd3, 8'd3, 4'd1, 0);
        applyStimulus(0, 1, 1, 1, 8'hFD, 8'd3, 4'd2, 0);
        applyStimulus(0, 1, 1, 1, 8'hFE, 8'd4, 4'd3, 0);
        applyStimulus(0, 1, 1, 0, 8'd1, 8'd7, 4'd4, 0);
        checkValue("rnd_-9", 16'(bus2.res), 16'hFFF);
        applyStimulus(0, 1, 1, 0, 8'd1, 8'd8, 4'd5, 0);
        checkValue("rnd_-8", 16'(bus2.res), 16'h000);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);
        checkValue("rnd_1x8", 16'(bus2.res), 16'd1);

        // Stall pattern; inputs presented while ce=0 must be ignored.
        stallCe = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < 7; i++)
            applyStimulus(0, stallCe[i], 1, i[0], 8'(i * 17 + 10), 8'(i * 5 + 3), 4'(8 + i), 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);

        // Reset with samples in flight.
        applyStimulus(0, 1, 1, 0, 8'd7, 8'd9, 4'd13, 0);
        applyStimulus(0, 1, 1, 1, 8'hF0, 8'd9, 4'd14, 0);
        applyStimulus(1, 1, 1, 0, 8'd2, 8'd2, 4'd12, 0);
        applyStimulus(0, 1, 1, 0, 8'd11, 8'd12, 4'd15, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);

        // Randomized traffic with stalls, clears and occasional resets.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom), 8'($urandom),
                          4'($urandom), $urandom_range(0, 9) == 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'd0, 8'd0, 4'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
